// File: rtl/program_counter_if.sv
// Request/result bundle between the fetch control logic and the program counter.
// The master side drives the requests and the jump target; the slave side returns the count and its flags.
interface program_counter_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] i_in;
   logic             i_load;
   logic             i_inc;
   logic             i_clr;
   logic [WIDTH-1:0] o_out;
   logic             o_wrap;
   logic             o_jumped;

   modport master (
      output i_in, i_load, i_inc, i_clr,
      input  o_out, o_wrap, o_jumped
   );

   modport slave (
      input  i_in, i_load, i_inc, i_clr,
      output o_out, o_wrap, o_jumped
   );
endinterface

// File: rtl/program_counter.sv
// Program counter with clr > load > inc > hold priority; one-cycle latency, all outputs registered.
// No backpressure: a request is acted on at the edge where it is sampled.
module pc_incrementer #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_a,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry
);
   assign {o_carry, o_sum} = {1'b0, i_a} + {{WIDTH{1'b0}}, 1'b1};
endmodule

module program_counter #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input logic               clk,
   input logic               rst,
   program_counter_if.slave  pc
);
   logic [WIDTH-1:0] r_out;
   logic             r_wrap;
   logic             r_jumped;

   logic [WIDTH-1:0] w_inc_val;
   logic             w_carry;
   logic [WIDTH-1:0] w_next;
   logic             w_wrap_next;
   logic             w_jumped_next;

   pc_incrementer #(.WIDTH(WIDTH)) u_inc (
      .i_a     (r_out),
      .o_sum   (w_inc_val),
      .o_carry (w_carry)
   );

   // The adder carry is exactly the all-ones rollover condition.
   always_comb begin
      w_next        = r_out;
      w_wrap_next   = 1'b0;
      w_jumped_next = 1'b0;
      if (pc.i_clr) begin
         w_next = RESET_VECTOR;
      end else if (pc.i_load) begin
         w_next        = pc.i_in;
         w_jumped_next = 1'b1;
      end else if (pc.i_inc) begin
         w_next      = w_inc_val;
         w_wrap_next = w_carry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out    <= RESET_VECTOR;
         r_wrap   <= 1'b0;
         r_jumped <= 1'b0;
      end else begin
         r_out    <= w_next;
         r_wrap   <= w_wrap_next;
         r_jumped <= w_jumped_next;
      end
   end

   assign pc.o_out    = r_out;
   assign pc.o_wrap   = r_wrap;
   assign pc.o_jumped = r_jumped;
endmodule

// File: tb/tb_program_counter.sv
// Directed and randomized checks of the program counter against hand-computed values and a small model.
module tb_program_counter;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [15:0] m_out;
   logic        m_wrap;
   logic        m_jumped;

   program_counter_if #(.WIDTH(16)) pc_if ();

   program_counter #(.WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
      .clk (clk),
      .rst (rst),
      .pc  (pc_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [15:0] o, input logic w, input logic j);
      chk({tag, "_out"}, pc_if.o_out, o);
      chk({tag, "_wrap"}, {15'd0, pc_if.o_wrap}, {15'd0, w});
      chk({tag, "_jumped"}, {15'd0, pc_if.o_jumped}, {15'd0, j});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] d, input logic ld, input logic ic, input logic cl);
      pc_if.i_in   = d;
      pc_if.i_load = ld;
      pc_if.i_inc  = ic;
      pc_if.i_clr  = cl;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      drive(16'h0000, 1'b0, 1'b0, 1'b0);
      #2;
      chk3("reset", 16'h0000, 1'b0, 1'b0);
      tick();
      chk3("reset_held", 16'h0000, 1'b0, 1'b0);
      rst = 1'b0;

      // 1: async reset mid-cycle, then three increments
      drive(16'h1234, 1'b1, 1'b0, 1'b0);
      tick();
      chk3("load1234", 16'h1234, 1'b0, 1'b1);
      drive(16'h0000, 1'b0, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk3("async_rst", 16'h0000, 1'b0, 1'b0);
      tick();
      chk3("rst_over_inc", 16'h0000, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk3("inc_seq", k[15:0], 1'b0, 1'b0);
      end

      // 2: load beats inc
      drive(16'hABCD, 1'b1, 1'b1, 1'b0);
      tick();
      chk3("load_inc", 16'hABCD, 1'b0, 1'b1);
      drive(16'h0000, 1'b0, 1'b1, 1'b0);
      tick();
      chk3("inc_after_load", 16'hABCE, 1'b0, 1'b0);

      // load held high keeps jumped asserted
      drive(16'h0010, 1'b1, 1'b0, 1'b0);
      tick();
      drive(16'h0020, 1'b1, 1'b0, 1'b0);
      tick();
      chk3("load_held", 16'h0020, 1'b0, 1'b1);

      // 3: rollover
      drive(16'hFFFF, 1'b1, 1'b0, 1'b0);
      tick();
      chk3("load_ffff", 16'hFFFF, 1'b0, 1'b1);
      drive(16'h0000, 1'b0, 1'b1, 1'b0);
      tick();
      chk3("wrap", 16'h0000, 1'b1, 1'b0);
      tick();
      chk3("after_wrap", 16'h0001, 1'b0, 1'b0);

      // 4: clr beats load and inc
      drive(16'h00FF, 1'b1, 1'b0, 1'b0);
      tick();
      drive(16'h5555, 1'b1, 1'b1, 1'b1);
      tick();
      chk3("clr_all", 16'h0000, 1'b0, 1'b0);

      // 5: hold with in toggling
      drive(16'h0042, 1'b1, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 10; k++) begin
         drive(16'h0042 ^ (16'h1111 * k[15:0]) ^ 16'hF0F0, 1'b0, 1'b0, 1'b0);
         tick();
         chk3("hold", 16'h0042, 1'b0, 1'b0);
      end

      // 6: random run against a behavioural model
      m_out    = 16'h0042;
      m_wrap   = 1'b0;
      m_jumped = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         drive(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b1;
            #1;
            m_out    = 16'h0000;
            m_wrap   = 1'b0;
            m_jumped = 1'b0;
            chk("rnd_rst_out", pc_if.o_out, m_out);
            rst = 1'b0;
         end
         @(posedge clk);
         if (pc_if.i_clr) begin
            m_out = 16'h0000; m_wrap = 1'b0; m_jumped = 1'b0;
         end else if (pc_if.i_load) begin
            m_out = pc_if.i_in; m_wrap = 1'b0; m_jumped = 1'b1;
         end else if (pc_if.i_inc) begin
            m_wrap = (m_out == 16'hFFFF); m_out = m_out + 16'd1; m_jumped = 1'b0;
         end else begin
            m_wrap = 1'b0; m_jumped = 1'b0;
         end
         #1;
         chk3("rnd", m_out, m_wrap, m_jumped);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
